datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL have no parameters; widths are fixed: data 8 bits, register address 4 bits, opcode 3 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 write_alu  input  1  register write-data select: 1 = alu_out, 0 = imm_data (when is_load=0).
REQ-005 alu_opcode  input  3  ALU operation select.
REQ-006 ram_data  input  8  load data from memory.
REQ-007 imm_data  input  8  immediate operand.
REQ-008 write_addr  input  4  destination register index.
REQ-009 ra_addr  input  4  read port A register index.
REQ-010 rb_addr  input  4  read port B register index.
REQ-011 write_en  input  1  register-file write enable.
REQ-012 is_load  input  1  register write-data select: 1 = ram_data; highest priority.
REQ-013 imm_flag  input  1  ALU operand B select: 1 = imm_data, 0 = read_b.
REQ-014 read_a  output  8  contents of register ra_addr.
REQ-015 read_b  output  8  contents of register rb_addr.
REQ-016 alu_zero  output  1  1 when alu_out == 0.
REQ-017 alu_carry  output  1  ALU carry/borrow/shifted-out bit.
REQ-018 alu_out  output  8  ALU result.

Function
REQ-019 Register file SHALL hold 16 x 8-bit registers, all writable, including r0.
REQ-020 Reads SHALL be combinational; read_a and read_b SHALL change in the same cycle as ra_addr and rb_addr.
REQ-021 On the rising edge with write_en=1 and rst=0, reg[write_addr] SHALL be loaded with wdata = is_load ? ram_data : (write_alu ? alu_out : imm_data).
REQ-022 With write_en=0, no register SHALL change.
REQ-023 ALU SHALL be combinational; operand A = read_a; operand B = imm_flag ? imm_data : read_b.
REQ-024 Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHL, 111 SHR.
REQ-025 ADD: {alu_carry, alu_out} = A + B (9-bit sum); results wrap modulo 256.
REQ-026 SUB: alu_out = (A - B) mod 256; alu_carry = 1 exactly when A < B (borrow).
REQ-027 AND/OR/XOR: bitwise on A and B; alu_carry = 0.
REQ-028 NOT: alu_out = ~A; B is ignored; alu_carry = 0.
REQ-029 SHL: alu_out = {A[6:0],0}; alu_carry = A[7]. SHR: logical, alu_out = {0,A[7:1]}; alu_carry = A[0].
REQ-030 alu_zero SHALL be derived from the final alu_out for every opcode.
REQ-031 A read of write_addr in the same cycle as a write SHALL return the old value unless bypass is compiled in (REQ-035).
REQ-032 ALU-result writeback SHALL use the current cycle's alu_out, so `rX <= rX op rY` completes in one cycle.

Reset
REQ-033 When rst=1 at a rising edge, all 16 registers SHALL clear to 0x00, with priority over write_en.
REQ-034 After reset with imm_flag=0, outputs SHALL be read_a=read_b=0x00, alu_out=0x00 (for opcodes other than NOT), and alu_zero=1.

Configuration
REQ-035 Macro DATAPATH_BYPASS_EN: when defined, a read port whose address equals write_addr while write_en=1 SHALL return wdata combinationally (write-through). When undefined, REQ-031 applies.

Structure
REQ-036 Opcode constants (ADD..SHR) and the data and address widths SHALL live in the shared package datapath_pkg.
REQ-037 The ALU SHALL be a separate sub-module named alu (inputs a, b, opcode; outputs out, carry, zero); the register file SHALL be implemented inline.

Verification
REQ-038 Reset, then read all 16 addresses -> every read returns 0x00 and alu_zero=1.
REQ-039 Immediate load: is_load=0, write_alu=0, imm_data=0x7F, write_addr=3, write_en=1 for one edge -> ra_addr=3 reads 0x7F.
REQ-040 ADD with carry: r1=0xF0, r2=0x20, opcode ADD, write_alu=1 into r4 -> alu_out=0x10, alu_carry=1; next cycle r4 reads 0x10.
REQ-041 SUB to zero and borrow: r1=0x20 minus r1 -> alu_out=0x00, alu_zero=1, alu_carry=0; 0x10 minus 0x20 -> alu_out=0xF0, alu_carry=1.
REQ-042 Shifts and NOT: A=0x81 -> SHL gives 0x02 with carry=1; SHR gives 0x40 with carry=1; NOT gives 0x7E with carry=0.
REQ-043 Load priority: is_load=1, write_alu=1, ram_data=0xA5 into r9 -> r9 reads 0xA5; with write_en=0 the same stimulus leaves r9 unchanged.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared widths and ALU opcode constants for the datapath and its ALU.
package datapath_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int OP_W   = 3;
    localparam int NUM_REGS = 1 << ADDR_W;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_NOT = 3'b101;
    localparam logic [OP_W-1:0] OP_SHL = 3'b110;
    localparam logic [OP_W-1:0] OP_SHR = 3'b111;

endpackage

// File: rtl/datapath_alu.sv
// Combinational 8-bit ALU: add/sub with carry-borrow, logic ops, NOT, 1-bit shifts.
module alu
    import datapath_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   opcode,
    output logic [DATA_W-1:0] out,
    output logic              carry,
    output logic              zero
);

    always_comb begin
        out   = '0;
        carry = 1'b0;
        case (opcode)
            OP_ADD: {carry, out} = {1'b0, a} + {1'b0, b};
            // Bit 8 of the 9-bit difference is set exactly when a < b.
            OP_SUB: {carry, out} = {1'b0, a} - {1'b0, b};
            OP_AND: out = a & b;
            OP_OR:  out = a | b;
            OP_XOR: out = a ^ b;
            OP_NOT: out = ~a;
            OP_SHL: begin
                out   = {a[DATA_W-2:0], 1'b0};
                carry = a[DATA_W-1];
            end
            OP_SHR: begin
                out   = {1'b0, a[DATA_W-1:1]};
                carry = a[0];
            end
            default: begin
                out   = '0;
                carry = 1'b0;
            end
        endcase
    end

    assign zero = (out == '0);

endmodule

// File: rtl/datapath.sv
// 16x8 register file with two combinational read ports feeding the ALU.
// Optional write-through bypass on the read ports: define DATAPATH_BYPASS_EN.
module datapath
    import datapath_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              write_alu,
    input  logic [OP_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] imm_data,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    input  logic              write_en,
    input  logic              is_load,
    input  logic              imm_flag,
    output logic [DATA_W-1:0] read_a,
    output logic [DATA_W-1:0] read_b,
    output logic              alu_zero,
    output logic              alu_carry,
    output logic [DATA_W-1:0] alu_out
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] reg_a;
    logic [DATA_W-1:0] reg_b;
    logic [DATA_W-1:0] operand_b;
    logic [DATA_W-1:0] wdata;

    assign reg_a = regs[ra_addr];
    assign reg_b = regs[rb_addr];

    // The ALU works on stored values so a bypassed alu_out never loops back into itself.
    assign operand_b = imm_flag ? imm_data : reg_b;

    alu u_alu (
        .a      (reg_a),
        .b      (operand_b),
        .opcode (alu_opcode),
        .out    (alu_out),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    assign wdata = is_load ? ram_data : (write_alu ? alu_out : imm_data);

`ifdef DATAPATH_BYPASS_EN
    assign read_a = (write_en && (ra_addr == write_addr)) ? wdata : reg_a;
    assign read_b = (write_en && (rb_addr == write_addr)) ? wdata : reg_b;
`else
    assign read_a = reg_a;
    assign read_b = reg_b;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[write_addr] <= wdata;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for datapath; expectations are hand-computed constants.
`timescale 1ns/1ps
module tb_datapath;

    logic       clk;
    logic       rst;
    logic       write_alu;
    logic [2:0] alu_opcode;
    logic [7:0] ram_data;
    logic [7:0] imm_data;
    logic [3:0] write_addr;
    logic [3:0] ra_addr;
    logic [3:0] rb_addr;
    logic       write_en;
    logic       is_load;
    logic       imm_flag;
    logic [7:0] read_a;
    logic [7:0] read_b;
    logic       alu_zero;
    logic       alu_carry;
    logic [7:0] alu_out;

    int n_checks = 0;
    int n_fail   = 0;

    datapath dut (
        .clk        (clk),
        .rst        (rst),
        .write_alu  (write_alu),
        .alu_opcode (alu_opcode),
        .ram_data   (ram_data),
        .imm_data   (imm_data),
        .write_addr (write_addr),
        .ra_addr    (ra_addr),
        .rb_addr    (rb_addr),
        .write_en   (write_en),
        .is_load    (is_load),
        .imm_flag   (imm_flag),
        .read_a     (read_a),
        .read_b     (read_b),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry),
        .alu_out    (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after a rising edge; combinational checks follow 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_imm(input logic [3:0] addr, input logic [7:0] data);
        is_load    = 1'b0;
        write_alu  = 1'b0;
        imm_data   = data;
        write_addr = addr;
        write_en   = 1'b1;
        tick();
        write_en   = 1'b0;
    endtask

    task automatic alu_case(input string tag, input logic [2:0] op,
                            input logic [7:0] exp_out, input logic exp_c);
        alu_opcode = op;
        #1;
        check_val({tag, "_out"}, 32'(alu_out), 32'(exp_out));
        check_val({tag, "_carry"}, 32'(alu_carry), 32'(exp_c));
        check_val({tag, "_zero"}, 32'(alu_zero), 32'(exp_out == 8'h00));
    endtask

    initial begin
        rst = 1'b1; write_alu = 1'b0; alu_opcode = 3'b000; ram_data = 8'h00;
        imm_data = 8'h00; write_addr = 4'd0; ra_addr = 4'd0; rb_addr = 4'd0;
        write_en = 1'b0; is_load = 1'b0; imm_flag = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // All registers clear after reset
        for (int i = 0; i < 16; i++) begin
            ra_addr = 4'(i);
            rb_addr = 4'(15 - i);
            #1;
            check_val("rst_read_a", 32'(read_a), 32'h00);
            check_val("rst_read_b", 32'(read_b), 32'h00);
            check_val("rst_alu_out", 32'(alu_out), 32'h00);
            check_val("rst_alu_zero", 32'(alu_zero), 32'h1);
        end

        // Immediate load into r3
        wr_imm(4'd3, 8'h7F);
        ra_addr = 4'd3;
        #1;
        check_val("imm_load_r3", 32'(read_a), 32'h7F);

        // Same-cycle read of the register being written
        imm_data = 8'h11; write_addr = 4'd3; write_en = 1'b1; write_alu = 1'b0;
        #1;
`ifdef DATAPATH_BYPASS_EN
        check_val("same_cycle_read", 32'(read_a), 32'h11);
`else
        check_val("same_cycle_read", 32'(read_a), 32'h7F);
`endif
        tick();
        write_en = 1'b0;
        #1;
        check_val("r3_after_write", 32'(read_a), 32'h11);

        // ADD with carry, ALU writeback into r4
        wr_imm(4'd1, 8'hF0);
        wr_imm(4'd2, 8'h20);
        ra_addr = 4'd1; rb_addr = 4'd2; imm_flag = 1'b0; alu_opcode = 3'b000;
        write_alu = 1'b1; write_addr = 4'd4; write_en = 1'b1;
        #1;
        check_val("add_out", 32'(alu_out), 32'h10);
        check_val("add_carry", 32'(alu_carry), 32'h1);
        check_val("add_zero", 32'(alu_zero), 32'h0);
        tick();
        write_en = 1'b0;
        ra_addr = 4'd4;
        #1;
        check_val("add_wb_r4", 32'(read_a), 32'h10);

        // SUB to zero, then SUB with borrow
        wr_imm(4'd1, 8'h20);
        ra_addr = 4'd1; rb_addr = 4'd1;
        alu_case("sub_zero", 3'b001, 8'h00, 1'b0);
        ra_addr = 4'd4; rb_addr = 4'd1;
        alu_case("sub_borrow", 3'b001, 8'hF0, 1'b1);

        // Shifts and NOT on 0x81
        wr_imm(4'd5, 8'h81);
        ra_addr = 4'd5;
        alu_case("shl", 3'b110, 8'h02, 1'b1);
        alu_case("shr", 3'b111, 8'h40, 1'b1);
        alu_case("not", 3'b101, 8'h7E, 1'b0);

        // Logic ops and ADD against the immediate operand
        imm_flag = 1'b1; imm_data = 8'h0F;
        alu_case("and_imm", 3'b010, 8'h01, 1'b0);
        alu_case("or_imm",  3'b011, 8'h8F, 1'b0);
        alu_case("xor_imm", 3'b100, 8'h8E, 1'b0);
        alu_case("add_imm", 3'b000, 8'h90, 1'b0);
        imm_data = 8'h81;
        alu_case("xor_self_zero", 3'b100, 8'h00, 1'b0);
        imm_flag = 1'b0;

        // r1 <= r1 + r2 in one cycle
        ra_addr = 4'd1; rb_addr = 4'd2; alu_opcode = 3'b000;
        write_alu = 1'b1; is_load = 1'b0; write_addr = 4'd1; write_en = 1'b1;
        tick();
        write_en = 1'b0;
        #1;
        check_val("rmw_r1", 32'(read_a), 32'h40);

        // Load priority over ALU select, then write_en=0 holds
        is_load = 1'b1; write_alu = 1'b1; ram_data = 8'hA5; write_addr = 4'd9; write_en = 1'b1;
        tick();
        write_en = 1'b0;
        ra_addr = 4'd9;
        #1;
        check_val("load_r9", 32'(read_a), 32'hA5);
        ram_data = 8'h3C;
        tick();
        check_val("hold_r9", 32'(read_a), 32'hA5);
        rb_addr = 4'd5;
        #1;
        check_val("hold_r5", 32'(read_b), 32'h81);

        // Reset wins over a simultaneous write
        is_load = 1'b0; write_alu = 1'b0; imm_data = 8'h55; write_addr = 4'd9; write_en = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0; write_en = 1'b0;
        #1;
        check_val("rst_prio_r9", 32'(read_a), 32'h00);
        check_val("rst_prio_r5", 32'(read_b), 32'h00);
        check_val("rst_prio_zero", 32'(alu_zero), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
